fetch_stage: RTL and testbench

Fetch-side consumer of the hazard unit's control outputs: holds the program counter, selects the next PC from the EX-stage redirect source, drives the instruction-memory address, and owns the IF/ID pipeline register. It honours PC_write, IFID_write and IF_flush every cycle. It sits between instruction memory and the decode stage, so the stall and flush decisions made in ID/EX become architectural state here.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, redirect and IF/ID signals of the fetch stage; FETCH_PERF_CNT_EN adds counter outputs
interface fetch_stage_if;
  logic PC_write;
  logic IFID_write;
  logic IF_flush;
  logic [1:0] pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] IFID_instruction;
  logic [31:0] IFID_pc_plus4;
  logic IFID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  modport master (output PC_write, IFID_write, IF_flush, pc_src, branch_target, jump_target, jr_target, imem_rdata,
                  input imem_addr, IFID_instruction, IFID_pc_plus4, IFID_valid, stall_cnt, flush_cnt);
  modport slave (input PC_write, IFID_write, IF_flush, pc_src, branch_target, jump_target, jr_target, imem_rdata,
                 output imem_addr, IFID_instruction, IFID_pc_plus4, IFID_valid, stall_cnt, flush_cnt);
`else
  modport master (output PC_write, IFID_write, IF_flush, pc_src, branch_target, jump_target, jr_target, imem_rdata,
                  input imem_addr, IFID_instruction, IFID_pc_plus4, IFID_valid);
  modport slave (input PC_write, IFID_write, IF_flush, pc_src, branch_target, jump_target, jr_target, imem_rdata,
                 output imem_addr, IFID_instruction, IFID_pc_plus4, IFID_valid);
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register; FETCH_PERF_CNT_EN adds saturating stall/flush counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FLUSH_INSTR = 32'hFC00_0000
) (
  input logic clk,
  input logic rst_n,
  fetch_stage_if.slave f
);
  logic [31:0] pc, pc_plus4, target, pc_next;
  logic [31:0] instr, pc4;
  logic valid;
  assign pc_plus4 = pc + 32'd4;
  // a taken redirect wins over a PC stall so it is never lost
  always_comb begin
    target = f.pc_src == 2'b01 ? f.branch_target : f.pc_src == 2'b10 ? f.jump_target : f.jr_target;
    pc_next = f.pc_src != 2'b00 ? target & 32'hFFFF_FFFC : f.PC_write ? pc_plus4 : pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else pc <= pc_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr <= FLUSH_INSTR;
      pc4 <= 32'd0;
      valid <= 1'b0;
    end else if (f.IF_flush) begin
      instr <= FLUSH_INSTR;
      pc4 <= 32'd0;
      valid <= 1'b0;
    end else if (f.IFID_write) begin
      instr <= f.imem_rdata;
      pc4 <= pc_plus4;
      valid <= 1'b1;
    end
  assign f.imem_addr = pc;
  assign f.IFID_instruction = instr;
  assign f.IFID_pc_plus4 = pc4;
  assign f.IFID_valid = valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!f.PC_write && f.pc_src == 2'b00 && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (f.IF_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  assign f.stall_cnt = stall_cnt;
  assign f.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboard queue for fetch_stage; counter checks when FETCH_PERF_CNT_EN is defined
module tb_fetch_stage;
  localparam logic [31:0] FI = 32'hFC00_0000;
  localparam logic [31:0] BD = 32'h0000_0AA0, JD = 32'h0000_0BB0, RD = 32'h0000_0CC0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fetch_stage_if f();
  assign f.imem_rdata = f.imem_addr + 32'd1;
  fetch_stage #(.RESET_PC(32'h100), .FLUSH_INSTR(FI)) dut (.clk(clk), .rst_n(rst_n), .f(f));
  always #5 clk = ~clk;
  typedef struct {
    logic pw, iw, fl;
    logic [1:0] src;
    logic [31:0] b, j, r, pc, ins, p4;
    logic v;
  } vec_t;
  typedef struct {
    int idx;
    logic [31:0] pc, ins, p4;
    logic v;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  function automatic vec_t mk(logic pw, logic iw, logic fl, logic [1:0] src, logic [31:0] b, logic [31:0] j,
                              logic [31:0] r, logic [31:0] pc, logic [31:0] ins, logic [31:0] p4, logic v);
    vec_t t;
    t.pw = pw; t.iw = iw; t.fl = fl; t.src = src; t.b = b; t.j = j; t.r = r;
    t.pc = pc; t.ins = ins; t.p4 = p4; t.v = v;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic pw, input logic iw, input logic fl, input logic [1:0] src,
                       input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
    f.PC_write = pw; f.IFID_write = iw; f.IF_flush = fl; f.pc_src = src;
    f.branch_target = b; f.jump_target = j; f.jr_target = r;
  endtask
  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v);
    chk({tag, " pc"}, f.imem_addr, pc);
    chk({tag, " instr"}, f.IFID_instruction, ins);
    chk({tag, " pc4"}, f.IFID_pc_plus4, p4);
    chk({tag, " valid"}, {31'd0, f.IFID_valid}, {31'd0, v});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exp_t e;
    drive(1, 1, 0, 2'b00, BD, JD, RD);
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h104, 32'h101, 32'h104, 1));
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h108, 32'h105, 32'h108, 1));
    tbl.push_back(mk(1, 1, 0, 2'b10, BD, 32'h20, RD, 32'h20, 32'h109, 32'h10C, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 2'b00, BD, JD, RD, 32'h20, 32'h109, 32'h10C, 1));
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h24, 32'h21, 32'h24, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, BD, JD, RD, 32'h24, 32'h25, 32'h28, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, BD, JD, RD, 32'h24, 32'h25, 32'h28, 1));
    tbl.push_back(mk(0, 0, 1, 2'b00, BD, JD, RD, 32'h24, FI, 32'h0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 32'h400, JD, RD, 32'h400, FI, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h404, 32'h401, 32'h404, 1));
    tbl.push_back(mk(0, 1, 0, 2'b11, BD, JD, 32'h203, 32'h200, 32'h405, 32'h408, 1));
    tbl.push_back(mk(0, 0, 0, 2'b10, BD, 32'hFFFF_FFFF, RD, 32'hFFFF_FFFC, 32'h405, 32'h408, 1));
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h0, 32'hFFFF_FFFD, 32'h0, 1));
    tbl.push_back(mk(1, 1, 0, 2'b00, BD, JD, RD, 32'h4, 32'h1, 32'h4, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_state("reset", 32'h100, FI, 32'h0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset stall_cnt", f.stall_cnt, 32'h0);
    chk("reset flush_cnt", f.flush_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].src, tbl[i].b, tbl[i].j, tbl[i].r);
      e.idx = i; e.pc = tbl[i].pc; e.ins = tbl[i].ins; e.p4 = tbl[i].p4; e.v = tbl[i].v;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_state($sformatf("vec%0d", e.idx), e.pc, e.ins, e.p4, e.v);
      @(negedge clk);
    end
    chk("scoreboard drained", sb.size(), 0);
    @(posedge clk);
    #2;
    drive(1, 1, 1, 2'b01, 32'h400, JD, RD);
    rst_n = 1'b0;
    #1;
    chk_state("async reset", 32'h100, FI, 32'h0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("async reset stall_cnt", f.stall_cnt, 32'h0);
    chk("async reset flush_cnt", f.flush_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("reset holds over edge pc", f.imem_addr, 32'h100);
    @(negedge clk);
    drive(1, 1, 0, 2'b00, BD, JD, RD);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("first fetch after release", 32'h104, 32'h101, 32'h104, 1);
    @(negedge clk);
    drive(0, 0, 0, 2'b00, BD, JD, RD);
    repeat (5) @(posedge clk);
    #1;
    chk_state("five stalls", 32'h104, 32'h101, 32'h104, 1);
    @(negedge clk);
    drive(1, 0, 1, 2'b00, BD, JD, RD);
    repeat (2) @(posedge clk);
    #1;
    chk_state("two flushes", 32'h10C, FI, 32'h0, 0);
    @(negedge clk);
    drive(1, 1, 0, 2'b00, BD, JD, RD);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", f.stall_cnt, 32'd5);
    chk("flush_cnt", f.flush_cnt, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-count reset stall_cnt", f.stall_cnt, 32'h0);
    chk("mid-count reset flush_cnt", f.flush_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
